// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer BRAM write port between the CPU
// data-bus path and the front-panel renderer. Each requester has a small
// circular FIFO. A round-robin scheduler drains one entry per clock into a
// registered write port.
// Optional build macro FB_ARB_STATS_EN adds saturating stall/write counters.
module fb_write_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  input  logic              fp_valid,
  input  logic [ADDR_W-1:0] fp_addr,
  input  logic [DATA_W-1:0] fp_data,
  output logic              fp_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt,
  output logic [15:0]       fp_stall_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_FP  = 1'b1
  } grant_e;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [ENT_W-1:0] cpu_mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] fp_mem_q  [FIFO_DEPTH];
  logic [PTR_W-1:0] cpu_wptr_q, cpu_wptr_d, cpu_rptr_q, cpu_rptr_d;
  logic [PTR_W-1:0] fp_wptr_q,  fp_wptr_d,  fp_rptr_q,  fp_rptr_d;

  logic             cpu_empty, cpu_full, cpu_push, cpu_pop;
  logic             fp_empty,  fp_full,  fp_push,  fp_pop;
  logic [ENT_W-1:0] cpu_head, fp_head;

  grant_e           last_grant_q, last_grant_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // FIFO status: ready depends only on stored state, never on valid
  assign cpu_empty = (cpu_wptr_q == cpu_rptr_q);
  assign fp_empty  = (fp_wptr_q == fp_rptr_q);
  assign cpu_full  = (cpu_wptr_q == {~cpu_rptr_q[PTR_W-1], cpu_rptr_q[IDX_W-1:0]});
  assign fp_full   = (fp_wptr_q == {~fp_rptr_q[PTR_W-1], fp_rptr_q[IDX_W-1:0]});

  assign cpu_ready = ~cpu_full;
  assign fp_ready  = ~fp_full;
  assign cpu_push  = cpu_valid & ~cpu_full;
  assign fp_push   = fp_valid & ~fp_full;

  assign cpu_head  = cpu_mem_q[cpu_rptr_q[IDX_W-1:0]];
  assign fp_head   = fp_mem_q[fp_rptr_q[IDX_W-1:0]];

  // Pointer advance; natural wrap modulo 2*FIFO_DEPTH
  always_comb begin
    cpu_wptr_d = cpu_wptr_q + PTR_W'(cpu_push);
    cpu_rptr_d = cpu_rptr_q + PTR_W'(cpu_pop);
    fp_wptr_d  = fp_wptr_q + PTR_W'(fp_push);
    fp_rptr_d  = fp_rptr_q + PTR_W'(fp_pop);
  end

  // Round-robin scheduler: a tie goes to the requester not granted last
  always_comb begin
    cpu_pop      = 1'b0;
    fp_pop       = 1'b0;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (!cpu_empty && (fp_empty || last_grant_q == GRANT_FP)) begin
      cpu_pop                = 1'b1;
      last_grant_d           = GRANT_CPU;
      wr_en_d                = 1'b1;
      {wr_addr_d, wr_data_d} = cpu_head;
    end else if (!fp_empty) begin
      fp_pop                 = 1'b1;
      last_grant_d           = GRANT_FP;
      wr_en_d                = 1'b1;
      {wr_addr_d, wr_data_d} = fp_head;
    end
  end

  // FIFO storage writes (contents need no reset; pointers define validity)
  always_ff @(posedge clock) begin
    if (cpu_push) cpu_mem_q[cpu_wptr_q[IDX_W-1:0]] <= {cpu_addr, cpu_data};
    if (fp_push)  fp_mem_q[fp_wptr_q[IDX_W-1:0]]   <= {fp_addr, fp_data};
  end

  // State registers: pointers, grant history and the BRAM write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_wptr_q   <= '0;
      cpu_rptr_q   <= '0;
      fp_wptr_q    <= '0;
      fp_rptr_q    <= '0;
      last_grant_q <= GRANT_FP;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      cpu_wptr_q   <= cpu_wptr_d;
      cpu_rptr_q   <= cpu_rptr_d;
      fp_wptr_q    <= fp_wptr_d;
      fp_rptr_q    <= fp_rptr_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = ~cpu_empty | ~fp_empty | wr_en_q;

`ifdef FB_ARB_STATS_EN
  logic [15:0] cpu_stall_q, fp_stall_q, wr_cnt_q;

  // Saturating stall and write counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_stall_q <= '0;
      fp_stall_q  <= '0;
      wr_cnt_q    <= '0;
    end else begin
      if (cpu_valid && cpu_full && cpu_stall_q != 16'hFFFF) cpu_stall_q <= cpu_stall_q + 16'd1;
      if (fp_valid && fp_full && fp_stall_q != 16'hFFFF)    fp_stall_q  <= fp_stall_q + 16'd1;
      if (wr_en_q && wr_cnt_q != 16'hFFFF)                  wr_cnt_q    <= wr_cnt_q + 16'd1;
    end
  end

  assign cpu_stall_cnt = cpu_stall_q;
  assign fp_stall_cnt  = fp_stall_q;
  assign wr_cnt        = wr_cnt_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter. Accepted beats are queued per requester
// (address bit 8 identifies the source) and matched against BRAM writes.
module tb_fb_write_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_valid = 1'b0;
  logic [8:0] cpu_addr = '0;
  logic [7:0] cpu_data = '0;
  logic       cpu_ready;
  logic       fp_valid = 1'b0;
  logic [8:0] fp_addr = '0;
  logic [7:0] fp_data = '0;
  logic       fp_ready;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
`ifdef FB_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt, fp_stall_cnt, wr_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int wr_seen = 0;
  logic [16:0] q_cpu [$];
  logic [16:0] q_fp  [$];

  fb_write_arbiter #(.ADDR_W(9), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_ready (cpu_ready),
    .fp_valid  (fp_valid),
    .fp_addr   (fp_addr),
    .fp_data   (fp_data),
    .fp_ready  (fp_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
`ifdef FB_ARB_STATS_EN
    ,
    .cpu_stall_cnt (cpu_stall_cnt),
    .fp_stall_cnt  (fp_stall_cnt),
    .wr_cnt        (wr_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Scoreboard: every BRAM write must match the oldest outstanding beat of its source
  always @(negedge clock) begin
    logic [16:0] exp;
    if (reset_n && wr_en) begin
      wr_seen++;
      n_total++;
      if (wr_addr[8]) begin
        if (q_fp.size() == 0) begin
          $display("FAIL fp_write: got unexpected write %h/%h, expected none", wr_addr, wr_data);
        end else begin
          exp = q_fp.pop_front();
          if ({wr_addr, wr_data} !== exp)
            $display("FAIL fp_write: got %h expected %h", {wr_addr, wr_data}, exp);
          else n_pass++;
        end
      end else begin
        if (q_cpu.size() == 0) begin
          $display("FAIL cpu_write: got unexpected write %h/%h, expected none", wr_addr, wr_data);
        end else begin
          exp = q_cpu.pop_front();
          if ({wr_addr, wr_data} !== exp)
            $display("FAIL cpu_write: got %h expected %h", {wr_addr, wr_data}, exp);
          else n_pass++;
        end
      end
    end
  end

  task automatic apply_reset();
    cpu_valid = 1'b0;
    fp_valid  = 1'b0;
    reset_n   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 100 && busy; k++) @(negedge clock);
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b expected 0 within 100 cycles", name, busy);
    else n_pass++;
    n_total++;
    if (q_cpu.size() + q_fp.size() != 0)
      $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, q_cpu.size() + q_fp.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_total++;
    if ({wr_en, wr_addr, wr_data, busy} !== 19'd0)
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b expected all 0",
               wr_en, wr_addr, wr_data, busy);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clock);
    n_total++;
    if ({cpu_ready, fp_ready, busy, wr_en} !== 4'b1100)
      $display("FAIL reset_release: got ready=%b%b busy=%b en=%b expected 11 0 0",
               cpu_ready, fp_ready, busy, wr_en);
    else n_pass++;
`ifdef FB_ARB_STATS_EN
    n_total++;
    if ({cpu_stall_cnt, fp_stall_cnt, wr_cnt} !== 48'd0)
      $display("FAIL reset_stats: got %h %h %h expected 0", cpu_stall_cnt, fp_stall_cnt, wr_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_single_cpu();
    apply_reset();
    cpu_valid = 1'b1;
    cpu_addr  = 9'h012;
    cpu_data  = 8'hA5;
    n_total++;
    if (cpu_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", cpu_ready);
    else n_pass++;
    q_cpu.push_back({cpu_addr, cpu_data});
    @(negedge clock);
    cpu_valid = 1'b0;
    n_total++;
    if ({wr_en, busy} !== 2'b01) $display("FAIL single_lat1: got en/busy=%b%b expected 01", wr_en, busy);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if ({wr_en, busy, wr_addr, wr_data} !== {2'b11, 9'h012, 8'hA5})
      $display("FAIL single_write: got en=%b busy=%b %h/%h expected 1 1 012/a5", wr_en, busy, wr_addr, wr_data);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if ({wr_en, busy} !== 2'b00) $display("FAIL single_done: got en/busy=%b%b expected 00", wr_en, busy);
    else n_pass++;
    wait_idle("single");
  endtask

  task automatic test_contention();
    logic [8:0] ord [6];
    ord = '{9'h001, 9'h101, 9'h002, 9'h102, 9'h003, 9'h103};
    apply_reset();
    for (int n = 0; n < 9; n++) begin
      if (n < 3) begin
        cpu_valid = 1'b1; cpu_addr = 9'h001 + 9'(n); cpu_data = 8'h10 + 8'(n);
        fp_valid  = 1'b1; fp_addr  = 9'h101 + 9'(n); fp_data  = 8'h20 + 8'(n);
        q_cpu.push_back({cpu_addr, cpu_data});
        q_fp.push_back({fp_addr, fp_data});
      end else begin
        cpu_valid = 1'b0;
        fp_valid  = 1'b0;
      end
      if (n >= 2 && n <= 7) begin
        n_total++;
        if (wr_en !== 1'b1 || wr_addr !== ord[n-2])
          $display("FAIL contention_order%0d: got en=%b addr=%h expected 1 %h", n - 2, wr_en, wr_addr, ord[n-2]);
        else n_pass++;
      end
      if (n == 8) begin
        n_total++;
        if ({wr_en, busy} !== 2'b00) $display("FAIL contention_end: got en/busy=%b%b expected 00", wr_en, busy);
        else n_pass++;
      end
      @(negedge clock);
    end
    wait_idle("contention");
  endtask

  task automatic test_full_fifo();
    int ci = 0, fi = 0, stall_c = 0, stall_f = 0, cyc = 0, wr_start;
    bit cacc, facc;
    apply_reset();
    wr_start  = wr_seen;
    cpu_valid = 1'b1; cpu_addr = 9'h020; cpu_data = 8'h40;
    fp_valid  = 1'b1; fp_addr  = 9'h140; fp_data  = 8'hC0;
    while ((cpu_valid || fp_valid) && cyc < 200) begin
      cacc = cpu_valid && cpu_ready;
      facc = fp_valid && fp_ready;
      if (cpu_valid && !cpu_ready) stall_c++;
      if (fp_valid && !fp_ready) stall_f++;
      if (cacc) q_cpu.push_back({cpu_addr, cpu_data});
      if (facc) q_fp.push_back({fp_addr, fp_data});
      @(negedge clock);
      cyc++;
      if (cacc) begin
        ci++;
        if (ci < 12) begin cpu_addr = 9'h020 + 9'(ci); cpu_data = 8'h40 + 8'(ci); end
        else cpu_valid = 1'b0;
      end
      if (facc) begin
        fi++;
        if (fi < 10) begin fp_addr = 9'h140 + 9'(fi); fp_data = 8'hC0 + 8'(fi); end
        else fp_valid = 1'b0;
      end
    end
    n_total++;
    if (cpu_valid || fp_valid) $display("FAIL full_accept: got %0d/%0d beats accepted expected 12/10", ci, fi);
    else n_pass++;
    n_total++;
    if (stall_f == 0) $display("FAIL full_fp_stall: got %0d stall cycles expected >0", stall_f);
    else n_pass++;
    wait_idle("full");
    n_total++;
    if (wr_seen - wr_start != 22) $display("FAIL full_wr_count: got %0d expected 22", wr_seen - wr_start);
    else n_pass++;
`ifdef FB_ARB_STATS_EN
    n_total++;
    if ({cpu_stall_cnt, fp_stall_cnt, wr_cnt} !== {16'(stall_c), 16'(stall_f), 16'd22})
      $display("FAIL stats: got %0d %0d %0d expected %0d %0d 22",
               cpu_stall_cnt, fp_stall_cnt, wr_cnt, stall_c, stall_f);
    else n_pass++;
`endif
  endtask

  task automatic test_pointer_wrap();
    int rdy_bad = 0, en_bad = 0;
    apply_reset();
    for (int n = 0; n < 23; n++) begin
      if (n < 20) begin
        fp_valid = 1'b1; fp_addr = 9'h100 + 9'(n); fp_data = 8'(n);
        if (fp_ready !== 1'b1) rdy_bad++;
        q_fp.push_back({fp_addr, fp_data});
      end else fp_valid = 1'b0;
      if (wr_en !== ((n >= 2 && n <= 21) ? 1'b1 : 1'b0)) en_bad++;
      @(negedge clock);
    end
    n_total++;
    if (rdy_bad != 0) $display("FAIL wrap_ready: got %0d not-ready cycles expected 0", rdy_bad);
    else n_pass++;
    n_total++;
    if (en_bad != 0) $display("FAIL wrap_stream: got %0d wr_en deviations expected 0", en_bad);
    else n_pass++;
    wait_idle("wrap");
  endtask

  task automatic test_reset_mid();
    int stray = 0, bad = 0;
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      cpu_valid = 1'b1; cpu_addr = 9'h030 + 9'(n); cpu_data = 8'h50 + 8'(n);
      fp_valid  = 1'b1; fp_addr  = 9'h130 + 9'(n); fp_data  = 8'h60 + 8'(n);
      if (n == 0) begin
        q_cpu.push_back({cpu_addr, cpu_data});
        q_fp.push_back({fp_addr, fp_data});
      end
      @(negedge clock);
    end
    cpu_valid = 1'b0;
    fp_valid  = 1'b0;
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== 9'h130)
      $display("FAIL midreset_pre: got en=%b addr=%h expected 1 130", wr_en, wr_addr);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({wr_en, busy} !== 2'b00) $display("FAIL midreset_async: got en/busy=%b%b expected 00", wr_en, busy);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (wr_en) stray++;
      if ({cpu_ready, fp_ready, busy} !== 3'b110) bad++;
    end
    n_total++;
    if (stray != 0) $display("FAIL midreset_stray: got %0d writes expected 0", stray);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL midreset_idle: got %0d cycles not ready/idle expected 0", bad);
    else n_pass++;
    n_total++;
    if (q_cpu.size() + q_fp.size() != 0)
      $display("FAIL midreset_pending: got %0d beats outstanding expected 0", q_cpu.size() + q_fp.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_cpu();
    test_contention();
    test_full_fifo();
    test_pointer_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
